// File: rtl/shift_left_seq.sv
// Iterative logical-shift-left / normalise unit.
// Shifts the captured operand one bit per clock. Mode 0 shifts by a requested
// amount and reports bits lost off the MSB; mode 1 shifts until the MSB is set
// and reports how many shifts that took.
module shift_left_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] A,
  input  logic [SHW-1:0]   i,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [SHW-1:0]   shift_cnt,
  output logic             overflow,
  output logic             zero
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_r, next_state_s;
  logic [WIDTH-1:0] work_r;
  logic [SHW-1:0]   cnt_r;
  logic [SHW-1:0]   amt_r;
  logic             mode_r;
  logic             ovf_acc_r;
  logic             zero_acc_r;

  logic             accept_s;
  logic             no_shift_s;
  logic [WIDTH-1:0] shifted_s;
  logic [SHW-1:0]   cnt_inc_s;
  logic             last_shift_s;
  logic             ovf_next_s;
  logic             busy_d_s;
  logic             done_d_s;

  // Decode of the current operation: acceptance, early-out and shift-step values.
  always_comb begin
    accept_s   = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    // A zero operand in normalise mode never gets an MSB, so it finishes at once.
    no_shift_s = mode ? (A[WIDTH-1] || (A == {WIDTH{1'b0}})) : (i == {SHW{1'b0}});
    shifted_s  = {work_r[WIDTH-2:0], 1'b0};
    cnt_inc_s  = cnt_r + {{(SHW-1){1'b0}}, 1'b1};
    // Normalise stops when the bit about to become MSB is set.
    last_shift_s = mode_r ? work_r[WIDTH-2] : (cnt_inc_s == amt_r);
    ovf_next_s   = ovf_acc_r | (~mode_r & work_r[WIDTH-1]);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (accept_s) begin
          next_state_s = no_shift_s ? ST_DONE : ST_SHIFT;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (last_shift_s) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_SHIFT;
        end
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from the upcoming state so they can be registered.
  always_comb begin
    busy_d_s = 1'b0;
    done_d_s = 1'b0;
    case (next_state_s)
      ST_SHIFT: busy_d_s = 1'b1;
      ST_DONE:  done_d_s = 1'b1;
      default: begin
        busy_d_s = 1'b0;
        done_d_s = 1'b0;
      end
    endcase
  end

  // Registered busy/done handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_d_s;
      done <= done_d_s;
    end
  end

  // Work datapath and result registers; results change only on DONE entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      work_r     <= {WIDTH{1'b0}};
      cnt_r      <= {SHW{1'b0}};
      amt_r      <= {SHW{1'b0}};
      mode_r     <= 1'b0;
      ovf_acc_r  <= 1'b0;
      zero_acc_r <= 1'b0;
      result     <= {WIDTH{1'b0}};
      shift_cnt  <= {SHW{1'b0}};
      overflow   <= 1'b0;
      zero       <= 1'b0;
    end else if (accept_s) begin
      work_r     <= A;
      cnt_r      <= {SHW{1'b0}};
      amt_r      <= i;
      mode_r     <= mode;
      ovf_acc_r  <= 1'b0;
      zero_acc_r <= (A == {WIDTH{1'b0}});
      if (no_shift_s) begin
        result    <= A;
        shift_cnt <= {SHW{1'b0}};
        overflow  <= 1'b0;
        zero      <= (A == {WIDTH{1'b0}});
      end else begin
        result    <= result;
        shift_cnt <= shift_cnt;
        overflow  <= overflow;
        zero      <= zero;
      end
    end else if (state_r == ST_SHIFT) begin
      work_r    <= shifted_s;
      cnt_r     <= cnt_inc_s;
      ovf_acc_r <= ovf_next_s;
      if (last_shift_s) begin
        result    <= shifted_s;
        shift_cnt <= cnt_inc_s;
        overflow  <= ovf_next_s;
        zero      <= zero_acc_r;
      end else begin
        result    <= result;
        shift_cnt <= shift_cnt;
        overflow  <= overflow;
        zero      <= zero;
      end
    end else begin
      work_r <= work_r;
      cnt_r  <= cnt_r;
    end
  end

endmodule
